// File: rtl/pc_seq_unit.sv
// Registered program-counter unit: PC register, EX branch resolution with flush, and halt-drain FSM.
// Optional PC_PERF_CNT_EN adds registered branch/taken event counters.
module pc_seq_unit #(
  parameter int              ADDR_W      = 16,
  parameter int              IMM_W       = 9,
  parameter int              INSTR_BYTES = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              HALT_DRAIN  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              hlt_dec,
  input  logic              br_valid,
  input  logic              br_type,
  input  logic [2:0]        br_cond,
  input  logic [2:0]        br_flags,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_rs,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              flush,
  output logic              halted,
  output logic [1:0]        state_out
`ifdef PC_PERF_CNT_EN
  ,
  output logic [15:0]       br_count,
  output logic [15:0]       taken_count
`endif
);

  localparam int CNT_W = $clog2(HALT_DRAIN + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_r;
  logic [CNT_W-1:0]  drain_cnt;
  logic              halted_r;
  logic              cond_true;
  logic              taken;
  logic [ADDR_W-1:0] br_target;

  // Flags arrive packed as {Z,V,N}.
  function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] flags);
    logic z, v, n;
    z = flags[2];
    v = flags[1];
    n = flags[0];
    case (cond)
      3'b000:  cond_eval = !z;
      3'b001:  cond_eval = z;
      3'b010:  cond_eval = !z && !n;
      3'b011:  cond_eval = n;
      3'b100:  cond_eval = z || (!z && !n);
      3'b101:  cond_eval = n || z;
      3'b110:  cond_eval = v;
      default: cond_eval = 1'b1;
    endcase
  endfunction

  // Offset is in instruction units (halfwords); sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] pc,
                                                    input logic signed [IMM_W-1:0] imm);
    logic signed [ADDR_W-1:0] off;
    off = imm;
    rel_target = pc + ADDR_W'(INSTR_BYTES) + ADDR_W'(off <<< 1);
  endfunction

  always_comb begin
    cond_true   = cond_eval(br_cond, br_flags);
    taken       = br_valid && cond_true && (state != ST_HALTED);
    br_target   = br_type ? br_rs : rel_target(br_pc, br_imm);
    pc_next_seq = pc_r + ADDR_W'(INSTR_BYTES);
    flush       = taken && rst_n;
  end

  assign pc_out    = pc_r;
  assign halted    = halted_r;
  assign state_out = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r      <= RESET_VEC;
      state     <= ST_RUN;
      halted_r  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (taken) begin
            pc_r <= br_target;
          end else if (stall) begin
            pc_r <= pc_r;
          end else if (hlt_dec) begin
            state     <= ST_DRAIN;
            drain_cnt <= CNT_W'(HALT_DRAIN);
          end else begin
            pc_r <= pc_next_seq;
          end
        end
        ST_DRAIN: begin
          // A taken branch here means the HLT was on a wrong path.
          if (taken) begin
            pc_r      <= br_target;
            state     <= ST_RUN;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
            if (drain_cnt == CNT_W'(1)) begin
              state    <= ST_HALTED;
              halted_r <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          pc_r <= pc_r;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef PC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if (br_valid && (state != ST_HALTED)) br_count <= br_count + 16'd1;
      if (taken) taken_count <= taken_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised, registered program-counter unit for the pipelined core; successor to the combinational PC-next logic.
- Owns the PC register and the reset vector.
- Resolves conditional branches arriving from EX and issues a flush on redirect.
- Runs a halt-drain state machine, so halt asserts only once the pipeline has emptied. A taken branch during drain cancels the halt, because that halt was fetched on a wrong path.

Parameters:
ADDR_W, 16, PC and address width in bits
IMM_W, 9, branch offset width (signed, in instruction units)
INSTR_BYTES, 2, sequential PC increment
RESET_VEC, 0, PC value after reset
HALT_DRAIN, 4, cycles spent in DRAIN before halted asserts; must be >= 1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
stall  in  1  hold the PC (IF stall)
hlt_dec  in  1  instruction fetched at pc_out is HLT
br_valid  in  1  branch resolving in EX this cycle
br_type  in  1  0 = B (PC-relative), 1 = BR (register target)
br_cond  in  3  condition code
br_flags  in  3  flags {Z,V,N}
br_imm  in  IMM_W  signed offset
br_pc  in  ADDR_W  address of the resolving branch
br_rs  in  ADDR_W  register target for BR
pc_out  out  ADDR_W  registered fetch PC
pc_next_seq  out  ADDR_W  pc_out + INSTR_BYTES, combinational
flush  out  1  kill younger instructions, combinational
halted  out  1  registered; core halted
state_out  out  2  00 RUN, 01 DRAIN, 10 HALTED

Behaviour:
- Reset: rst_n=0 at an edge gives pc_out=RESET_VEC, state=RUN, halted=0, drain count=0. flush is forced to 0 while rst_n=0. Reset overrides everything, including mid-drain.
- Condition codes:
  - 000 !Z; 001 Z; 010 !Z&!N; 011 N
  - 100 Z|(!Z&!N); 101 N|Z; 110 V; 111 always
- taken = br_valid & cond_true & (state != HALTED).
- Target for B: br_pc + INSTR_BYTES + (sext(br_imm) << 1). Computed modulo 2^ADDR_W; wrap is silent, no error output.
- Target for BR: br_rs.
- flush = taken, in the same cycle as br_valid.
- RUN priority per edge, highest first:
  1. taken: pc_out <= target; stall and hlt_dec are ignored.
  2. stall: PC held; hlt_dec is ignored.
  3. hlt_dec: PC held; go to DRAIN; count <= HALT_DRAIN.
  4. otherwise: pc_out <= pc_next_seq; wraps to 0 at the top.
- DRAIN:
  - PC held; stall is ignored.
  - taken: pc_out <= target; state <= RUN; count cleared; halt cancelled.
  - Otherwise count decrements. When count==1 at an edge: state <= HALTED, halted <= 1.
  - Net effect: hlt_dec sampled at edge k gives halted=1 from edge k+HALT_DRAIN, provided no taken branch arrives.
- HALTED:
  - PC frozen at the HLT address; br_valid, stall and hlt_dec are ignored; flush=0.
  - Exit is by reset only.
- A not-taken br_valid has no effect beyond normal sequencing.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- When defined, adds two outputs:
  - br_count (16 bits): increments on every br_valid outside HALTED.
  - taken_count (16 bits): increments on every taken.
- Both counters are zeroed on reset, wrap at 0xFFFF->0, and are registered.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 3 idle cycles: pc_out 0x0000 -> 0x0002 -> 0x0004 -> 0x0006; flush=0.
- br_valid, type0, cond=001, Z=1, br_pc=0x0010, imm=9'h1FE (-2): flush=1 that cycle; next pc_out=0x000E. Same stimulus with Z=0: flush=0; PC sequential.
- Taken BR (cond=111, br_rs=0xBEEF) together with stall=1 and hlt_dec=1: next pc_out=0xBEEF; state stays RUN.
- hlt_dec at pc_out=0x0040, HALT_DRAIN=4:
  - state DRAIN for 4 cycles; halted=1 on the 4th edge.
  - pc_out stays 0x0040 throughout.
  - br_valid afterwards gives flush=0.
- hlt_dec, then 2 cycles later a taken B with target 0x0100: state returns to RUN; pc_out=0x0100; halted never asserts.
- PC wrap: pc_out=0xFFFE, then idle gives 0x0000. rst_n=0 during DRAIN gives pc_out=RESET_VEC, state RUN. With PC_PERF_CNT_EN: 3 branches, 2 taken gives br_count=3, taken_count=2.
